lfsr_crypt_engine: RTL and testbench
====================================

# lfsr_crypt_engine

Streaming byte encryptor that sits directly downstream of the LFSR tap lookup. It consumes the 8-bit tap pattern the lookup produces for the selected tap index and steps a 7-bit Fibonacci LFSR from a seed. Each incoming message byte is XORed with the current LFSR state, and the result goes out on a valid/ready stream toward data memory write-back.

## Interface
- `LFSR_W`, default 7: LFSR state width; taps use bits `[LFSR_W-1:0]`.
- `DATA_W`, default 8: message byte width; must be `LFSR_W+1`.
- `LEN_W`, default 7: width of the message length field (max 64 bytes).
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: one-cycle job request; honoured only in IDLE.
- `taps`, input, 8: tap pattern from the lookup; bit 7 is ignored.
- `seed`, input, `LFSR_W`: initial LFSR state.
- `len`, input, `LEN_W`: byte count for the job, 0..64.
- `in_valid`, input, 1: plaintext byte available.
- `in_ready`, output, 1: engine accepts a byte this cycle.
- `in_data`, input, `DATA_W`: plaintext byte.
- `out_valid`, output, 1: ciphertext byte available.
- `out_ready`, input, 1: consumer takes the byte this cycle.
- `out_data`, output, `DATA_W`: ciphertext byte.
- `busy`, output, 1: high in every state other than IDLE.
- `done`, output, 1: one-cycle pulse at the end of a job.
- `err`, output, 1: sticky illegal-configuration flag; cleared by the next accepted `start`.

## Operation
- **States:** IDLE, RUN, DONE. Encoded as an enum in the package.
- **IDLE, on `start`:**
  - Latch `taps[6:0]`, `seed` and `len`. Clear `err`.
  - If the latched taps or seed is 0, set `err=1` and go to DONE. A zero tap pattern is the lookup's default for an out-of-range index; a zero seed locks the LFSR.
  - Else if `len==0`, go to DONE with no transfers.
  - Else go to RUN.
- **Step function:** `next = {state[5:0], ^(state & taps)}`.
- **Encryption:**
  - Byte k (counting from 0) is encrypted with the LFSR state after k steps.
  - `out_data[6:0] = in_data[6:0] ^ state`.
  - `out_data[7]` is set by the configuration macro (see Configuration).
- **On each input accept** (`in_valid & in_ready`):
  - The encrypted byte goes into the output register and `out_valid` rises.
  - The state steps once.
  - The remaining count decrements.
- **Output register:**
  - Holds one entry.
  - `in_ready = (state==RUN) & (remaining!=0) & (!out_valid | out_ready)`.
- **RUN to DONE:** when the remaining count is 0 and the output register is empty, or is being drained this cycle.
- **DONE:** `done=1` for exactly one cycle, then IDLE.
- **Ignored `start`:** in RUN or DONE, `start` has no effect and no side effect.
- **Reset mid-job:** the job is abandoned and the in-flight output byte is discarded.

## Timing
- **Reset values:** `in_ready=0`, `out_valid=0`, `out_data=0`, `busy=0`, `done=0`, `err=0`, state IDLE, LFSR=0, count=0.
- **Start latency:** `start` at edge N puts the engine in RUN at N+1, so `in_ready` can be high from cycle N+1.
- **Data latency:** 1 cycle. A byte accepted at edge N is presented with `out_valid` after N.
- **Throughput:** one byte per cycle while `out_ready` stays high. A simultaneous drain and refill of the output register in the same cycle is legal.
- **Holding:** `out_data` and `out_valid` are stable while `out_valid & !out_ready`.
- **End of job:** `done` is asserted the cycle after the last output handshake. For an `err` or `len==0` job, `done` comes 1 cycle after `start`. `busy` falls together with `done` deasserting.

## Configuration
- **Macro:** `LFSR_CRYPT_PARITY_EN`.
- **Defined:** `out_data[7] = ^out_data[6:0]` (even parity over the ciphertext byte).
- **Undefined:** `out_data[7] = 0`. `in_data[7]` is ignored in both modes.

## Structure
- **Package `lfsr_crypt_pkg`:** `LFSR_W`, `DATA_W`, the state enum `crypt_state_t`, and the function `lfsr_next(state, taps)`.
- **Sub-module `lfsr_core`:**
  - Holds the state register.
  - Inputs: load (from seed) and step enable.
  - Output: current state.
- **Top level:** FSM, count, and output register.

## Test plan
- **Basic walk:** taps=0x60, seed=0x01, len=7, in_data=0x00 ×7 → out_data 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x41, then `done` pulse, `err=0`.
- **Parity:** taps=0x60, seed=0x01, in_data=0x41 → out_data 0x40 without the macro; 0xC0 with `LFSR_CRYPT_PARITY_EN`.
- **Illegal configuration:** taps=0x00 (or seed=0x00), `start` → `err=1`, `done` the next cycle, `in_ready` never high. A following legal `start` clears `err`.
- **Backpressure:** len=4 with `out_ready` low for 3 cycles after the first byte → `out_data` held stable, `in_ready=0`, order and values unchanged, exactly 4 output handshakes.
- **Zero length and restart:** `len=0` → `done` 1 cycle after `start`, no transfers. `start` asserted during RUN → ignored, byte count unaffected.
- **Reset mid-job:** `rst_n` low after 2 of 5 bytes → all outputs return to reset values immediately; a new job restarts from the new seed.

Source files
------------

// File: rtl/lfsr_crypt_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_crypt_pkg
// Shared definitions for the LFSR stream encryptor:
//   LFSR_W        - LFSR state width
//   DATA_W        - message byte width (one parity/pad bit above the LFSR width)
//   crypt_state_t - job FSM state encoding
//   lfsr_next()   - one Fibonacci step: shift left, feedback = parity of tapped bits
// ---------------------------------------------------------------------------
package lfsr_crypt_pkg;

    localparam int LFSR_W = 7;
    localparam int DATA_W = LFSR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } crypt_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] state,
        input logic [LFSR_W-1:0] taps
    );
        return {state[LFSR_W-2:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/lfsr_crypt_engine_core.sv
// ---------------------------------------------------------------------------
// lfsr_core
// LFSR state register for the crypt engine.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset (state clears to 0)
//   load_i   - load seed_i into the state (has priority over step_i)
//   step_i   - advance the state by one Fibonacci step
//   seed_i   - seed value
//   taps_i   - latched tap pattern used for the feedback
//   state_o  - current LFSR state
// ---------------------------------------------------------------------------
module lfsr_core #(
    parameter int LFSR_W = lfsr_crypt_pkg::LFSR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic [LFSR_W-1:0] taps_i,
    output logic [LFSR_W-1:0] state_o
);
    import lfsr_crypt_pkg::*;

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (step_i) begin
            state_d = lfsr_next(state_q, taps_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/lfsr_crypt_engine.sv
// ---------------------------------------------------------------------------
// lfsr_crypt_engine
// Streaming byte encryptor: each plaintext byte is XORed with the current
// 7-bit LFSR state, which then steps once. Results leave through a one-entry
// output register on a valid/ready stream.
// Optional build macro: LFSR_CRYPT_PARITY_EN - when defined, out_data[7]
// carries even parity over out_data[6:0]; otherwise out_data[7] is 0.
// Ports:
//   clk, rst_n            - clock / asynchronous active-low reset
//   start                 - job request, honoured only in IDLE
//   taps, seed, len       - job configuration (taps[7] ignored)
//   in_valid/in_ready/in_data    - plaintext stream
//   out_valid/out_ready/out_data - ciphertext stream
//   busy                  - high outside IDLE
//   done                  - one-cycle end-of-job pulse
//   err                   - sticky zero-taps / zero-seed flag, cleared by start
// ---------------------------------------------------------------------------
module lfsr_crypt_engine #(
    parameter int LFSR_W = lfsr_crypt_pkg::LFSR_W,
    parameter int DATA_W = lfsr_crypt_pkg::DATA_W,
    parameter int LEN_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        taps,
    input  logic [LFSR_W-1:0] seed,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import lfsr_crypt_pkg::*;

    crypt_state_t      state_q;
    logic [LFSR_W-1:0] taps_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              err_q;

    logic [LFSR_W-1:0] lfsr_state;
    logic [LFSR_W-1:0] cipher_lo;
    logic              cipher_msb;
    logic [DATA_W-1:0] cipher_d;
    logic              in_fire;
    logic              out_fire;
    logic              load_seed;

    // Bits above the LFSR width of taps and in_data carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{taps[7:LFSR_W], in_data[DATA_W-1:LFSR_W]};

    // A new byte may enter while count remains and the output slot is free
    // or being emptied in this same cycle.
    assign in_ready  = (state_q == ST_RUN) && (cnt_q != '0) && (!out_valid_q || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign load_seed = (state_q == ST_IDLE) && start;

    lfsr_core #(
        .LFSR_W (LFSR_W)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_seed),
        .step_i  (in_fire),
        .seed_i  (seed),
        .taps_i  (taps_q),
        .state_o (lfsr_state)
    );

    for (genvar gi = 0; gi < LFSR_W; gi++) begin : g_cipher
        assign cipher_lo[gi] = in_data[gi] ^ lfsr_state[gi];
    end

`ifdef LFSR_CRYPT_PARITY_EN
    assign cipher_msb = ^cipher_lo;
`else
    assign cipher_msb = 1'b0;
`endif

    assign cipher_d = {cipher_msb, cipher_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            taps_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        taps_q <= taps[LFSR_W-1:0];
                        cnt_q  <= len;
                        err_q  <= 1'b0;
                        // Zero taps is the lookup's out-of-range default and a
                        // zero seed never leaves zero: both are refused.
                        if ((taps[LFSR_W-1:0] == '0) || (seed == '0)) begin
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else if (len == '0) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (in_fire) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= cipher_d;
                        cnt_q       <= cnt_q - LEN_W'(1);
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                    end
                    if ((cnt_q == '0) && (!out_valid_q || out_ready)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err       = err_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_lfsr_crypt_engine.sv
module tb_lfsr_crypt_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] taps;
    logic [6:0] seed;
    logic [6:0] len;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_mis = 0;
    int n_hs  = 0;

    logic [7:0] sb[$];
    logic [6:0] m_state;
    logic [6:0] m_taps;

    always #5 clk = ~clk;

    lfsr_crypt_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .taps      (taps),
        .seed      (seed),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference cipher: byte encrypted with the model state, then model steps.
    task automatic model(input logic [7:0] d, output logic [7:0] e);
        logic [6:0] lo;
        lo = d[6:0] ^ m_state;
`ifdef LFSR_CRYPT_PARITY_EN
        e = {^lo, lo};
`else
        e = {1'b0, lo};
`endif
        m_state = {m_state[5:0], ^(m_state & m_taps)};
    endtask

    task automatic do_start(input logic [7:0] t, input logic [6:0] s, input logic [6:0] l);
        start = 1'b1; taps = t; seed = s; len = l;
        m_taps = t[6:0]; m_state = s;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] e);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            sb.push_back(e);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk(tag, 32'(done), 32'd1);
        tick();
    endtask

    // Scoreboard consumer: every output handshake pops one expected byte.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'(out_data), 32'hFFFF);
            end else begin
                chk("out_data", 32'(out_data), 32'(sb.pop_front()));
            end
            n_hs++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] walk_exp [7];
        logic [7:0] e;
        logic [7:0] e0;
        int hs0;

        walk_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h41};
        rst_n = 1'b0; start = 1'b0; taps = '0; seed = '0; len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        m_state = '0; m_taps = '0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic walk against the reference vector
        hs0 = n_hs;
        do_start(8'h60, 7'h01, 7'd7);
        @(negedge clk);
        chk("walk_busy", 32'(busy), 32'd1);
        chk("walk_in_ready", 32'(in_ready), 32'd1);
        tick();
        for (int i = 0; i < 7; i++) send(8'h00, walk_exp[i]);
        @(negedge clk);
        chk("walk_done_early", 32'(done), 32'd0);
        tick();
        @(negedge clk);
        chk("walk_done", 32'(done), 32'd1);
        chk("walk_err", 32'(err), 32'd0);
        chk("walk_hs", 32'(n_hs - hs0), 32'd7);
        tick();
        @(negedge clk);
        chk("walk_done_fall", 32'(done), 32'd0);
        chk("walk_busy_fall", 32'(busy), 32'd0);
        tick();

        // Parity / pad bit on top
        do_start(8'h60, 7'h01, 7'd1);
`ifdef LFSR_CRYPT_PARITY_EN
        send(8'h41, 8'hC0);
`else
        send(8'h41, 8'h40);
`endif
        wait_done("parity_done");

        // Illegal configurations: zero taps, taps with only bit 7, zero seed
        for (int k = 0; k < 3; k++) begin
            hs0 = n_hs;
            case (k)
                0: do_start(8'h00, 7'h55, 7'd3);
                1: do_start(8'h80, 7'h55, 7'd3);
                default: do_start(8'h60, 7'h00, 7'd3);
            endcase
            @(negedge clk);
            chk("illegal_done", 32'(done), 32'd1);
            chk("illegal_err", 32'(err), 32'd1);
            chk("illegal_in_ready", 32'(in_ready), 32'd0);
            tick();
            @(negedge clk);
            chk("illegal_done_fall", 32'(done), 32'd0);
            chk("illegal_busy_fall", 32'(busy), 32'd0);
            chk("illegal_err_sticky", 32'(err), 32'd1);
            chk("illegal_hs", 32'(n_hs - hs0), 32'd0);
            tick();
        end

        // Zero-length job right after an error clears err
        hs0 = n_hs;
        do_start(8'h60, 7'h05, 7'd0);
        @(negedge clk);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_err_clear", 32'(err), 32'd0);
        chk("zero_in_ready", 32'(in_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("zero_done_fall", 32'(done), 32'd0);
        chk("zero_hs", 32'(n_hs - hs0), 32'd0);
        tick();

        // Backpressure: output stalled three cycles after the first byte
        hs0 = n_hs;
        out_ready = 1'b0;
        do_start(8'h30, 7'h2A, 7'd4);
        model(8'h5A, e0);
        send(8'h5A, e0);
        in_valid = 1'b1;
        in_data  = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data_hold", 32'(out_data), 32'(e0));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        model(8'hC3, e); send(8'hC3, e);
        model(8'h7E, e); send(8'h7E, e);
        model(8'h11, e); send(8'h11, e);
        wait_done("bp_done");
        chk("bp_hs", 32'(n_hs - hs0), 32'd4);

        // start while RUN is ignored
        hs0 = n_hs;
        do_start(8'h60, 7'h09, 7'd3);
        model(8'hA5, e); send(8'hA5, e);
        start = 1'b1; seed = 7'h7F; len = 7'd10; taps = 8'h00;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("ign_busy", 32'(busy), 32'd1);
        chk("ign_err", 32'(err), 32'd0);
        chk("ign_in_ready", 32'(in_ready), 32'd1);
        tick();
        model(8'h3C, e); send(8'h3C, e);
        model(8'hFF, e); send(8'hFF, e);
        @(negedge clk);
        chk("ign_count_end", 32'(in_ready), 32'd0);
        tick();
        wait_done("ign_done");
        chk("ign_hs", 32'(n_hs - hs0), 32'd3);

        // Reset in the middle of a job
        do_start(8'h60, 7'h11, 7'd5);
        model(8'h01, e); send(8'h01, e);
        model(8'h02, e); send(8'h02, e);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        hs0 = n_hs;
        do_start(8'h48, 7'h33, 7'd2);
        model(8'h0F, e); send(8'h0F, e);
        model(8'hF0, e); send(8'hF0, e);
        wait_done("restart_done");
        chk("restart_hs", 32'(n_hs - hs0), 32'd2);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
